// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer-side enqueue handshake
// for the buffered UART transmitter.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_i;
    logic                 valid_i;
    logic                 ready_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART serialiser, LSB first,
// run-time parity mode and stop-bit count.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_DIV   = 868
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    uart_tx_fifo_if.slave               wr,
    input  logic [1:0]                  parity_mode_i,
    input  logic                        two_stop_i,
    output logic                        txd_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 ready_q, busy_q;
    logic                 push, pop, load;
    logic [DATA_BITS-1:0] head;

    state_t               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 pen_q, pen_d;
    logic                 two_q, two_d;
    logic                 stop2_q, stop2_d;
    logic                 txd_q, txd_d;
    logic                 baud_done;

    assign push      = wr.valid_i & ready_q;
    assign head      = mem[rd_ptr_q];
    assign baud_done = (baud_q == BW'(BAUD_DIV - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        pen_d   = pen_q;
        two_d   = two_q;
        stop2_d = stop2_q;
        txd_d   = txd_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                txd_d  = 1'b1;
                load   = (count_q != '0);
            end
            START: if (baud_done) begin
                baud_d  = '0;
                state_d = DATA;
                idx_d   = '0;
                txd_d   = shreg_q[0];
            end
            DATA: if (baud_done) begin
                baud_d = '0;
                if (idx_q == IW'(DATA_BITS - 1)) begin
                    stop2_d = 1'b0;
                    state_d = pen_q ? PARITY : STOP;
                    txd_d   = pen_q ? par_q : 1'b1;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    shreg_d = shreg_q >> 1;
                    txd_d   = shreg_q[1];
                end
            end
            PARITY: if (baud_done) begin
                baud_d  = '0;
                stop2_d = 1'b0;
                state_d = STOP;
                txd_d   = 1'b1;
            end
            STOP: if (baud_done) begin
                baud_d = '0;
                if (two_q && !stop2_q) begin
                    stop2_d = 1'b1;
                end else if (count_q != '0) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Frame config is sampled only when a frame is popped
        if (load) begin
            state_d = START;
            baud_d  = '0;
            txd_d   = 1'b0;
            shreg_d = head;
            pen_d   = ^parity_mode_i;
            par_d   = (^head) ^ (parity_mode_i == 2'b01);
            two_d   = two_stop_i;
        end
    end

    assign pop = load;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= wr.data_i;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            pen_q    <= 1'b0;
            two_q    <= 1'b0;
            stop2_q  <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            ready_q <= (count_d < CW'(FIFO_DEPTH));
            busy_q  <= (state_d != IDLE) || (count_d != '0);
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            pen_q   <= pen_d;
            two_q   <= two_d;
            stop2_q <= stop2_d;
            txd_q   <= txd_d;
        end
    end

    assign wr.ready_o   = ready_q;
    assign txd_o        = txd_q;
    assign busy_o       = busy_q;
    assign fifo_count_o = count_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench, line receiver
// checks every bit at its first and last clock.
module tb_uart_tx_fifo;
    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int BD    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DB-1:0] d;
        logic [1:0]    m;
        logic          two;
    } frame_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    pmode = 2'b00;
    logic          two   = 1'b0;
    logic          txd, busy;
    logic [CW-1:0] cnt;

    uart_tx_fifo_if #(.DATA_BITS(DB)) bus ();

    uart_tx_fifo #(
        .DATA_BITS (DB),
        .FIFO_DEPTH(DEPTH),
        .BAUD_DIV  (BD)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .wr           (bus),
        .parity_mode_i(pmode),
        .two_stop_i   (two),
        .txd_o        (txd),
        .busy_o       (busy),
        .fifo_count_o (cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     total = 0;
    int     bad   = 0;
    frame_t exp_q[$];
    bit     abort = 1'b0;
    int     rx_starts = 0;
    int     rx_done = 0;
    int     last_start = 0;
    int     prev_start = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // line receiver: pops the expected frame at each start bit
    initial begin
        frame_t      f;
        logic [15:0] bits;
        int          nb;
        forever begin
            @(negedge clk);
            if (rst_n && !abort && txd === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_frame", 1, 0);
                    repeat (12 * BD) @(negedge clk);
                end else begin
                    f = exp_q.pop_front();
                    prev_start = last_start;
                    last_start = cyc;
                    rx_starts++;
                    bits = '1;
                    bits[0] = 1'b0;
                    for (int i = 0; i < DB; i++) bits[1+i] = f.d[i];
                    nb = 1 + DB;
                    if (f.m == 2'b01 || f.m == 2'b10) begin
                        bits[nb] = (f.m == 2'b10) ? ^f.d : ~^f.d;
                        nb++;
                    end
                    nb += f.two ? 2 : 1;
                    for (int k = 0; k < nb * BD; k++) begin
                        if (k > 0) @(negedge clk);
                        if (abort) break;
                        if (k % BD == 0 || k % BD == BD - 1)
                            chk($sformatf("d%0h_bit%0d", f.d, k / BD),
                                txd, bits[k/BD]);
                    end
                    if (!abort) rx_done++;
                end
            end
        end
    end

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        int n;
        int n0;
        bit ok;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1, latency and frame length
        exp_q.push_back('{8'h33, 2'b00, 1'b0});
        bus.data_i  = 8'h33;
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk("t1_pre_fall", txd, 1);
        chk("t1_cnt1", cnt, 1);
        @(negedge clk);
        chk("t1_fall", txd, 0);
        chk("t1_cnt0", cnt, 0);
        n = 0;
        while (busy && n < 20 * BD) begin
            @(negedge clk);
            n++;
        end
        chk("t1_busy_len", n, 10 * BD);
        chk("t1_rx", rx_done, 1);

        // even then odd parity, back to back
        pmode = 2'b10;
        exp_q.push_back('{8'h33, 2'b10, 1'b0});
        exp_q.push_back('{8'h33, 2'b01, 1'b0});
        bus.data_i  = 8'h33;
        bus.valid_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        pmode = 2'b01;
        chk("t2_cnt", cnt, 1);
        wait_idle(40 * BD);
        pmode = 2'b00;
        chk("t2_gap", last_start - prev_start, 11 * BD);
        chk("t2_rx", rx_done, 3);

        // 8N2
        two = 1'b1;
        exp_q.push_back('{8'h5A, 2'b00, 1'b1});
        bus.data_i  = 8'h5A;
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        @(negedge clk);
        two = 1'b0;
        chk("t3_fall", txd, 0);
        n = 0;
        while (busy && n < 20 * BD) begin
            @(negedge clk);
            n++;
        end
        chk("t3_busy_len", n, 11 * BD);

        // overfill while the first frame is on the line
        for (int i = 0; i < 20; i++) begin
            bus.data_i  = 8'(8'hA0 + i);
            bus.valid_i = 1'b1;
            chk($sformatf("t4_ready%0d", i), bus.ready_o, i <= 16);
            if (i <= 16) exp_q.push_back('{8'(8'hA0 + i), 2'b00, 1'b0});
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        chk("t4_full_cnt", cnt, 16);
        chk("t4_full_ready", bus.ready_o, 0);

        // push offered across the pop edge while full
        bus.data_i  = 8'hEE;
        bus.valid_i = 1'b1;
        n = 0;
        while (cnt == CW'(16) && n < 20 * BD) begin
            @(negedge clk);
            n++;
        end
        bus.valid_i = 1'b0;
        chk("t5_full_pop", cnt, 15);

        // push exactly on a pop edge at count 5
        n = 0;
        while (cnt != CW'(5) && n < 200 * BD) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach5", cnt, 5);
        repeat (10 * BD - 1) @(negedge clk);
        chk("t5_pre", cnt, 5);
        exp_q.push_back('{8'hC5, 2'b00, 1'b0});
        bus.data_i  = 8'hC5;
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk("t5_same", cnt, 5);
        wait_idle(200 * BD);
        chk("t5_rx", rx_done, 22);
        chk("sb_empty", exp_q.size(), 0);

        // reset in the middle of frame 2
        n0 = rx_starts;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{8'(8'h11 * (i + 1)), 2'b00, 1'b0});
            bus.data_i  = 8'(8'h11 * (i + 1));
            bus.valid_i = 1'b1;
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        n = 0;
        while (rx_starts < n0 + 2 && n < 30 * BD) begin
            @(negedge clk);
            n++;
        end
        repeat (3 * BD) @(negedge clk);
        chk("t6_cnt_before", cnt, 3);
        chk("t6_busy_before", busy, 1);
        abort = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_txd", txd, 1);
        chk("t6_cnt", cnt, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready", bus.ready_o, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (12 * BD) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk("t6_line_idle", ok, 1);
        abort = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
